// File: rtl/serial_frame_arbiter.sv
// Round-robin arbiter granting one serial transmitter to NUM_CH FIFOs, one whole frame at a time.
// Grant/si_req 1 cycle after eligibility; pops are routed combinationally; GAP_CYCLES idle gap after each frame.
module serial_frame_arbiter #(
  parameter int NUM_CH     = 4,
  parameter int FRAME_POPS = 32,
  parameter int GAP_CYCLES = 12,
  parameter int CNT_W      = 16
) (
  input  logic              s_clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ch_req,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic [NUM_CH-1:0] ch_data,
  output logic [NUM_CH-1:0] ch_pop,
  output logic              si_req,
  output logic              si_datain,
  input  logic              si_pop,
  output logic [NUM_CH-1:0] grant,
  output logic              busy,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic              proto_err
);

  localparam int IW = $clog2(NUM_CH);
  localparam int PW = $clog2(FRAME_POPS + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;

  state_t            state, state_nxt;
  logic [IW-1:0]     last_grant, last_grant_nxt;
  logic [IW-1:0]     sel, idx;
  logic              sel_vld;
  logic [NUM_CH-1:0] elig, grant_nxt;
  logic              si_req_nxt, proto_err_nxt;
  logic [PW-1:0]     pop_cnt, pop_cnt_nxt;
  logic [GW-1:0]     gap_cnt, gap_cnt_nxt;
  logic [CNT_W-1:0]  frame_cnt_nxt;

  assign elig = ch_req & ch_en;

  // Scan offsets from farthest to nearest so the nearest eligible channel after last_grant wins.
  always_comb begin
    sel     = last_grant;
    sel_vld = 1'b0;
    idx     = last_grant;
    for (int k = NUM_CH; k >= 1; k--) begin
      idx = IW'((int'(last_grant) + k) % NUM_CH);
      if (elig[idx]) begin
        sel     = idx;
        sel_vld = 1'b1;
      end
    end
  end

  assign busy      = (state != IDLE);
  assign ch_pop    = (state == ACTIVE && si_pop) ? grant : '0;
  assign si_datain = (state == ACTIVE) ? ch_data[last_grant] : 1'b0;

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    si_req_nxt     = si_req;
    last_grant_nxt = last_grant;
    pop_cnt_nxt    = pop_cnt;
    gap_cnt_nxt    = gap_cnt;
    frame_cnt_nxt  = frame_cnt;
    proto_err_nxt  = 1'b0;
    case (state)
      IDLE: begin
        proto_err_nxt = si_pop;
        if (sel_vld) begin
          grant_nxt      = NUM_CH'(1) << sel;
          last_grant_nxt = sel;
          si_req_nxt     = 1'b1;
          pop_cnt_nxt    = '0;
          state_nxt      = ACTIVE;
        end
      end
      ACTIVE: begin
        if (si_pop) begin
          // Underflowing pops are flagged but still count toward the frame.
          proto_err_nxt = !ch_req[last_grant];
          if (pop_cnt == PW'(FRAME_POPS - 1)) begin
            pop_cnt_nxt   = PW'(FRAME_POPS);
            si_req_nxt    = 1'b0;
            grant_nxt     = '0;
            gap_cnt_nxt   = GW'(GAP_CYCLES - 1);
            frame_cnt_nxt = frame_cnt + 1'b1;
            state_nxt     = GAP;
          end else begin
            pop_cnt_nxt = pop_cnt + 1'b1;
          end
        end
      end
      GAP: begin
        proto_err_nxt = si_pop;
        if (gap_cnt == '0) begin
          state_nxt = IDLE;
        end else begin
          gap_cnt_nxt = gap_cnt - 1'b1;
        end
      end
      default: begin
        state_nxt  = IDLE;
        grant_nxt  = '0;
        si_req_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge s_clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      si_req     <= 1'b0;
      last_grant <= IW'(NUM_CH - 1);
      pop_cnt    <= '0;
      gap_cnt    <= '0;
      frame_cnt  <= '0;
      proto_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      si_req     <= si_req_nxt;
      last_grant <= last_grant_nxt;
      pop_cnt    <= pop_cnt_nxt;
      gap_cnt    <= gap_cnt_nxt;
      frame_cnt  <= frame_cnt_nxt;
      proto_err  <= proto_err_nxt;
    end
  end

endmodule

// File: tb/tb_serial_frame_arbiter.sv
// Randomized self-checking bench for serial_frame_arbiter against a round-robin reference model.
module tb_serial_frame_arbiter;

  localparam int NUM_CH     = 4;
  localparam int FRAME_POPS = 32;
  localparam int GAP_CYCLES = 12;
  localparam int CNT_W      = 16;

  logic              s_clk = 1'b0;
  logic              rst;
  logic [NUM_CH-1:0] ch_req, ch_en, ch_data;
  logic [NUM_CH-1:0] ch_pop;
  logic              si_req, si_datain, si_pop;
  logic [NUM_CH-1:0] grant;
  logic              busy;
  logic [CNT_W-1:0]  frame_cnt;
  logic              proto_err;

  int n_tests = 0;
  int n_fail  = 0;
  int perr_total = 0;
  int multi_hot  = 0;
  int m_last;

  always #5 s_clk = ~s_clk;

  serial_frame_arbiter #(
    .NUM_CH(NUM_CH), .FRAME_POPS(FRAME_POPS), .GAP_CYCLES(GAP_CYCLES), .CNT_W(CNT_W)
  ) dut (
    .s_clk(s_clk), .rst(rst), .ch_req(ch_req), .ch_en(ch_en), .ch_data(ch_data),
    .ch_pop(ch_pop), .si_req(si_req), .si_datain(si_datain), .si_pop(si_pop),
    .grant(grant), .busy(busy), .frame_cnt(frame_cnt), .proto_err(proto_err)
  );

  always @(negedge s_clk) begin
    if (proto_err === 1'b1) perr_total++;
    if (!$onehot0(ch_pop)) multi_hot++;
  end

  // Reference arbitration: first eligible channel after the last winner, wrapping.
  function automatic int rr_pick(input int last, input logic [NUM_CH-1:0] elig);
    for (int k = 1; k <= NUM_CH; k++) begin
      int c;
      c = (last + k) % NUM_CH;
      if (elig[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [NUM_CH-1:0] onehot(input int ch);
    return NUM_CH'(1) << ch;
  endfunction

  task automatic step();
    @(posedge s_clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; si_pop = 1'b0; ch_req = '0; ch_en = '0; ch_data = '0;
    step();
    step();
    rst = 1'b0;
    m_last = NUM_CH - 1;
  endtask

  task automatic wait_grant(output int cyc);
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (si_req !== 1'b1 && cyc < 200);
  endtask

  // Drives random pops for the granted channel; tallies cycles whose routing, data or grant disagree with the model.
  task automatic run_frame(input int ch, input int npops, input bit scramble, output int pops, output int bad);
    logic [NUM_CH-1:0] exp_pop;
    pops = 0;
    bad  = 0;
    for (int cyc = 0; cyc < npops * 4 + 20 && pops < npops; cyc++) begin
      ch_data = NUM_CH'($urandom);
      if (scramble) begin
        ch_en  = NUM_CH'($urandom);
        ch_req = NUM_CH'($urandom) | onehot(ch);
      end
      si_pop = ($urandom_range(0, 2) != 0);
      #1;
      exp_pop = si_pop ? onehot(ch) : '0;
      if (ch_pop !== exp_pop || si_datain !== ch_data[ch] || grant !== onehot(ch) || si_req !== 1'b1) bad++;
      if (si_pop) pops++;
      step();
    end
    si_pop = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ch_req = '1; ch_en = '1; si_pop = 1'b1; ch_data = '1;
    step();
    step();
    n_tests++; if (grant !== '0) begin n_fail++; $display("FAIL reset_grant: got %b want 0000", grant); end
    n_tests++; if (si_req !== 1'b0) begin n_fail++; $display("FAIL reset_si_req: got %b want 0", si_req); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++; if (frame_cnt !== '0) begin n_fail++; $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt); end
    n_tests++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL reset_proto_err: got %b want 0", proto_err); end
    n_tests++; if (ch_pop !== '0 || si_datain !== 1'b0) begin n_fail++; $display("FAIL reset_route: ch_pop %b datain %b want 0000/0", ch_pop, si_datain); end
    do_reset();
  endtask

  task automatic test_single();
    int pops, bad, cyc, p0;
    do_reset();
    p0 = perr_total;
    ch_en = 4'b0001; ch_req = 4'b0001;
    #1;
    n_tests++; if (si_req !== 1'b0) begin n_fail++; $display("FAIL single_pre_req: got %b want 0", si_req); end
    step();
    n_tests++; if (grant !== 4'b0001 || si_req !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL single_latency: grant %b si_req %b busy %b want 0001/1/1", grant, si_req, busy); end
    run_frame(0, FRAME_POPS, 1'b0, pops, bad);
    n_tests++; if (bad !== 0 || pops !== FRAME_POPS) begin n_fail++; $display("FAIL single_frame: bad %0d pops %0d want 0/%0d", bad, pops, FRAME_POPS); end
    n_tests++; if (si_req !== 1'b0 || grant !== '0 || busy !== 1'b1) begin n_fail++; $display("FAIL single_end: si_req %b grant %b busy %b want 0/0000/1", si_req, grant, busy); end
    n_tests++; if (frame_cnt !== 1) begin n_fail++; $display("FAIL single_frame_cnt: got %0d want 1", frame_cnt); end
    wait_grant(cyc);
    n_tests++; if (cyc !== GAP_CYCLES + 1 || grant !== 4'b0001) begin n_fail++; $display("FAIL single_gap: cycles %0d grant %b want %0d/0001", cyc, grant, GAP_CYCLES + 1); end
    run_frame(0, FRAME_POPS, 1'b0, pops, bad);
    ch_req = '0;
    n_tests++; if (bad !== 0 || frame_cnt !== 2) begin n_fail++; $display("FAIL single_back_to_back: bad %0d frame_cnt %0d want 0/2", bad, frame_cnt); end
    repeat (GAP_CYCLES + 2) step();
    n_tests++; if (busy !== 1'b0 || si_req !== 1'b0 || perr_total - p0 !== 0) begin n_fail++; $display("FAIL single_idle: busy %b si_req %b perr %0d want 0/0/0", busy, si_req, perr_total - p0); end
  endtask

  task automatic test_round_robin();
    int pops, bad, cyc, exp, p0, mh0;
    do_reset();
    p0 = perr_total; mh0 = multi_hot;
    ch_en = '1; ch_req = '1;
    for (int r = 0; r < 5; r++) begin
      exp = rr_pick(m_last, ch_req & ch_en);
      wait_grant(cyc);
      n_tests++; if (grant !== onehot(exp)) begin n_fail++; $display("FAIL rr_grant round %0d: got %b want %b", r, grant, onehot(exp)); end
      run_frame(exp, FRAME_POPS, 1'b0, pops, bad);
      n_tests++; if (bad !== 0 || pops !== FRAME_POPS) begin n_fail++; $display("FAIL rr_frame round %0d: bad %0d pops %0d want 0/%0d", r, bad, pops, FRAME_POPS); end
      m_last = exp;
    end
    n_tests++; if (frame_cnt !== 5) begin n_fail++; $display("FAIL rr_frame_cnt: got %0d want 5", frame_cnt); end
    n_tests++; if (multi_hot - mh0 !== 0 || perr_total - p0 !== 0) begin n_fail++; $display("FAIL rr_clean: multi_hot %0d perr %0d want 0/0", multi_hot - mh0, perr_total - p0); end
  endtask

  task automatic test_random();
    int pops, bad, cyc, exp;
    do_reset();
    for (int r = 0; r < 8; r++) begin
      do begin
        ch_en  = NUM_CH'($urandom);
        ch_req = NUM_CH'($urandom);
      end while ((ch_en & ch_req) == '0);
      exp = rr_pick(m_last, ch_req & ch_en);
      wait_grant(cyc);
      n_tests++; if (grant !== onehot(exp)) begin n_fail++; $display("FAIL rand_grant round %0d: got %b want %b (req %b en %b)", r, grant, onehot(exp), ch_req, ch_en); end
      run_frame(exp, FRAME_POPS, 1'b1, pops, bad);
      n_tests++; if (bad !== 0 || pops !== FRAME_POPS) begin n_fail++; $display("FAIL rand_frame round %0d: bad %0d pops %0d want 0/%0d", r, bad, pops, FRAME_POPS); end
      m_last = exp;
    end
    n_tests++; if (frame_cnt !== 8) begin n_fail++; $display("FAIL rand_frame_cnt: got %0d want 8", frame_cnt); end
  endtask

  task automatic test_mask();
    int pops, bad, pops2, bad2, cyc, exp;
    do_reset();
    ch_req = '1; ch_en = 4'b1010;
    for (int r = 0; r < 3; r++) begin
      exp = rr_pick(m_last, ch_req & ch_en);
      wait_grant(cyc);
      n_tests++; if (grant !== onehot(exp)) begin n_fail++; $display("FAIL mask_grant round %0d: got %b want %b", r, grant, onehot(exp)); end
      if (r < 2) begin
        run_frame(exp, FRAME_POPS, 1'b0, pops, bad);
      end else begin
        run_frame(exp, 10, 1'b0, pops, bad);
        ch_en = 4'b1000;
        run_frame(exp, FRAME_POPS - 10, 1'b0, pops2, bad2);
        pops += pops2; bad += bad2;
      end
      n_tests++; if (bad !== 0 || pops !== FRAME_POPS) begin n_fail++; $display("FAIL mask_frame round %0d: bad %0d pops %0d want 0/%0d", r, bad, pops, FRAME_POPS); end
      m_last = exp;
    end
    n_tests++; if (frame_cnt !== 3 || si_req !== 1'b0) begin n_fail++; $display("FAIL mask_disable_midframe: frame_cnt %0d si_req %b want 3/0", frame_cnt, si_req); end
    for (int r = 0; r < 2; r++) begin
      exp = rr_pick(m_last, ch_req & ch_en);
      wait_grant(cyc);
      n_tests++; if (grant !== onehot(exp)) begin n_fail++; $display("FAIL mask_after_clear %0d: got %b want %b", r, grant, onehot(exp)); end
      run_frame(exp, FRAME_POPS, 1'b0, pops, bad);
      m_last = exp;
    end
  endtask

  task automatic test_underflow();
    int pops, bad, pops2, bad2, cyc, p0;
    do_reset();
    ch_en = 4'b0001; ch_req = 4'b0001;
    wait_grant(cyc);
    p0 = perr_total;
    run_frame(0, 5, 1'b0, pops, bad);
    ch_req = '0; si_pop = 1'b1;
    #1;
    n_tests++; if (ch_pop !== 4'b0001) begin n_fail++; $display("FAIL underflow_route: got %b want 0001", ch_pop); end
    step();
    si_pop = 1'b0; ch_req = 4'b0001;
    n_tests++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL underflow_perr: got %b want 1", proto_err); end
    step();
    n_tests++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL underflow_perr_width: got %b want 0", proto_err); end
    run_frame(0, FRAME_POPS - 6, 1'b0, pops2, bad2);
    ch_req = '0;
    n_tests++; if (bad + bad2 !== 0 || si_req !== 1'b0 || frame_cnt !== 1) begin n_fail++; $display("FAIL underflow_count: bad %0d si_req %b frame_cnt %0d want 0/0/1", bad + bad2, si_req, frame_cnt); end
    repeat (GAP_CYCLES + 2) step();
    n_tests++; if (perr_total - p0 !== 1) begin n_fail++; $display("FAIL underflow_pulses: got %0d want 1", perr_total - p0); end
  endtask

  task automatic test_stray();
    int pops, bad, cyc, p0;
    do_reset();
    p0 = perr_total;
    si_pop = 1'b1;
    #1;
    n_tests++; if (ch_pop !== '0) begin n_fail++; $display("FAIL stray_idle_route: got %b want 0000", ch_pop); end
    step();
    si_pop = 1'b0;
    n_tests++; if (proto_err !== 1'b1 || si_req !== 1'b0) begin n_fail++; $display("FAIL stray_idle_perr: perr %b si_req %b want 1/0", proto_err, si_req); end
    ch_en = 4'b0001; ch_req = 4'b0001;
    wait_grant(cyc);
    run_frame(0, FRAME_POPS, 1'b0, pops, bad);
    ch_req = '0;
    si_pop = 1'b1;
    #1;
    n_tests++; if (ch_pop !== '0 || busy !== 1'b1) begin n_fail++; $display("FAIL stray_gap_route: ch_pop %b busy %b want 0000/1", ch_pop, busy); end
    step();
    si_pop = 1'b0;
    n_tests++; if (proto_err !== 1'b1 || frame_cnt !== 1) begin n_fail++; $display("FAIL stray_gap_perr: perr %b frame_cnt %0d want 1/1", proto_err, frame_cnt); end
    repeat (GAP_CYCLES + 2) step();
    n_tests++; if (frame_cnt !== 1 || busy !== 1'b0) begin n_fail++; $display("FAIL stray_after: frame_cnt %0d busy %b want 1/0", frame_cnt, busy); end
    ch_req = '1; ch_en = '0;
    repeat (5) step();
    n_tests++; if (si_req !== 1'b0 || grant !== '0) begin n_fail++; $display("FAIL disabled_no_grant: si_req %b grant %b want 0/0000", si_req, grant); end
    n_tests++; if (perr_total - p0 !== 2) begin n_fail++; $display("FAIL stray_pulses: got %0d want 2", perr_total - p0); end
  endtask

  task automatic test_reset_mid();
    int pops, bad, cyc, exp;
    do_reset();
    ch_en = '1; ch_req = 4'b0100;
    for (int r = 0; r < 2; r++) begin
      exp = rr_pick(m_last, ch_req & ch_en);
      wait_grant(cyc);
      n_tests++; if (grant !== onehot(exp)) begin n_fail++; $display("FAIL rstmid_grant %0d: got %b want %b", r, grant, onehot(exp)); end
      run_frame(exp, (r == 0) ? FRAME_POPS : 10, 1'b0, pops, bad);
      m_last = exp;
    end
    rst = 1'b1; ch_req = '1;
    step();
    n_tests++; if (grant !== '0 || si_req !== 1'b0 || frame_cnt !== 0 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_clear: grant %b si_req %b frame_cnt %0d busy %b want 0000/0/0/0", grant, si_req, frame_cnt, busy); end
    rst = 1'b0;
    m_last = NUM_CH - 1;
    exp = rr_pick(m_last, ch_req & ch_en);
    step();
    n_tests++; if (grant !== onehot(exp) || si_req !== 1'b1) begin n_fail++; $display("FAIL rstmid_restart: grant %b si_req %b want %b/1", grant, si_req, onehot(exp)); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_random();
    test_mask();
    test_underflow();
    test_stray();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached after %0d checks", n_tests);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_frame_arbiter.md
Name: serial_frame_arbiter

Overview:
- Shares one serial_interface transmitter between NUM_CH channel FIFOs; one whole frame is granted at a time.
- Selects the next channel by round-robin over enabled, requesting channels.
- Drives req and routes datain/pop between the granted FIFO and the serial interface.
- Enforces an inter-frame gap so the transmitter finishes its EOF before the next frame begins.

Parameters:
- NUM_CH, 4, number of channel FIFOs (2..8).
- FRAME_POPS, 32, pops the transmitter issues per frame; grant ends after this many.
- GAP_CYCLES, 12, cycles req is held low after a frame before re-arbitration; must be ≥ EOF length + 4.
- CNT_W, 16, width of frame counter.

Ports:
- s_clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- ch_req  in  NUM_CH  per-channel FIFO not-empty/frame-ready.
- ch_en  in  NUM_CH  per-channel enable mask.
- ch_data  in  NUM_CH  per-channel serial data bit (FIFO head).
- ch_pop  out  NUM_CH  per-channel pop, combinational: si_pop AND grant[i] AND state==ACTIVE.
- si_req  out  1  req to serial interface, registered.
- si_datain  out  1  datain to serial interface; ch_data[granted] in ACTIVE, else 0 (combinational).
- si_pop  in  1  pop from serial interface.
- grant  out  NUM_CH  one-hot granted channel, registered; all-zero when not ACTIVE.
- busy  out  1  high in ACTIVE or GAP.
- frame_cnt  out  CNT_W  completed frames, wraps modulo 2^CNT_W.
- proto_err  out  1  one-cycle pulse on protocol violation.

Behaviour:
- Reset (synchronous, takes priority over all events):
  - state=IDLE; grant=0; si_req=0; busy=0; frame_cnt=0; proto_err=0; pop_cnt=0; gap_cnt=0.
  - last_grant=NUM_CH-1, so channel 0 wins first.
- States IDLE, ACTIVE, GAP.
- IDLE:
  - elig = ch_req & ch_en.
  - If elig≠0: select the first set bit searching from last_grant+1 upward, wrapping modulo NUM_CH.
  - Next edge: grant=onehot(sel), last_grant=sel, si_req=1, pop_cnt=0, state→ACTIVE.
  - Latency from elig rising to si_req/grant high: 1 cycle.
- ACTIVE:
  - si_req=1; si_datain=ch_data[sel]; ch_pop[sel]=si_pop.
  - Each si_pop increments pop_cnt (width clog2(FRAME_POPS+1)).
  - On the si_pop that brings pop_cnt to FRAME_POPS, next edge: si_req=0, grant=0, gap_cnt=GAP_CYCLES-1, frame_cnt+=1, state→GAP.
  - Grant is held for the whole frame regardless of ch_req/ch_en changes on any channel; a frame is never aborted except by reset.
- GAP:
  - si_req=0; grant=0; all ch_pop=0.
  - gap_cnt decrements each cycle; at gap_cnt==0, next edge state→IDLE.
  - GAP therefore lasts exactly GAP_CYCLES cycles.
- proto_err is a registered 1-cycle pulse on the edge after any of:
  - si_pop while state is IDLE or GAP; the pop is ignored and not routed.
  - si_pop in ACTIVE while ch_req[sel]==0 (FIFO underflow); the pop is still routed and counted.
- No pop is ever routed to more than one channel; ch_pop is all-zero outside ACTIVE.
- Simultaneous requests: only the round-robin winner is granted; losers keep ch_req high and are served in later rounds.
- A channel requesting alone is granted back-to-back, separated by GAP.
- Disabled channels (ch_en=0) are never granted; an all-zero elig keeps IDLE with si_req=0.
- Reset mid-ACTIVE: all outputs drop the next edge, the frame is not counted, and round-robin restarts at channel 0.

Test Plan:
1. Single channel: ch_en=4'b0001, ch_req[0]=1, transmitter issues 32 pops → grant=0001 and si_req=1 one cycle after ch_req; ch_pop[0] mirrors si_pop; si_req=0 one cycle after 32nd pop; frame_cnt=1; next si_req rises 12+1 cycles later.
2. Round-robin: all four channels requesting, all enabled → grant sequence 0001, 0010, 0100, 1000, 0001; frame_cnt=5 after five frames; every ch_pop pulse is on the granted channel only.
3. Mask: ch_req=1111, ch_en=1010 → grants alternate 0010, 1000. Clearing ch_en[1] mid-frame still completes that frame (32 pops) and the next grant is 1000.
4. Underflow: drop ch_req[0] during its frame, then pulse si_pop → proto_err pulses once; pop_cnt still advances; frame completes after 32 pops.
5. Stray pop: pulse si_pop in IDLE and again in GAP → proto_err pulses each time, ch_pop stays 0000, frame_cnt is unchanged.
6. Reset mid-frame: assert rst after 10 pops with grant=0100 → the next edge gives grant=0, si_req=0, frame_cnt=0; with all channels requesting after reset, the first grant is 0001.
